psg_bus_writer: RTL and testbench
=================================

PSG_BUS_WRITER -- requirements
Module: psg_bus_writer

Interface
REQ-001 SHALL have parameter MIN_STROBE, default 2: minimum cycles ce_n_o/we_n_o are held low per byte (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: strobe cycles before abort when PSG_WR_TIMEOUT_EN is defined (range 2..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clock_i in 1 (all logic on its rising edge); res_n_i in 1 (asynchronous, active-low).
REQ-004 SHALL have ports: cmd_valid_i in 1 (command offered); cmd_ready_o out 1 (command accepted when both high).
REQ-005 SHALL have ports: cmd_type_i in 2 (00 tone period, 01 attenuation, 10 noise control, 11 raw byte); cmd_chan_i in 2 (channel 0..3); cmd_data_i in 10 (payload).
REQ-006 SHALL have PSG-side ports: ce_n_o out 1; we_n_o out 1; d_o out 8 (d_o[7] is the latch/data flag); ready_i in 1 (PSG ready).
REQ-007 SHALL have status ports: busy_o out 1 (high outside IDLE); err_o out 1 (sticky timeout flag; constant 0 when the feature is compiled out).

Function
REQ-008 SHALL encode tone commands as two bytes: byte A = {1, chan[1:0], 0, data[3:0]}, then byte B = {0, 0, data[9:4]}.
REQ-009 SHALL encode attenuation as one byte {1, chan, 1, data[3:0]}; noise as one byte {1, 1, 1, 0, 0, data[2:0]}, ignoring cmd_chan_i; raw as one byte data[7:0].
REQ-010 SHALL implement states IDLE, SETUP, STROBE, RELEASE, plus NEXT for the second tone byte.
REQ-011 IDLE: cmd_ready_o=1. On cmd_valid_i=1, latch type, channel and data, and go to SETUP with d_o driven from the latched byte.
REQ-012 SETUP (1 cycle): d_o stable, ce_n_o=we_n_o=1; next state STROBE.
REQ-013 STROBE: ce_n_o=we_n_o=0, d_o stable; leave only after at least MIN_STROBE cycles in STROBE and with ready_i sampled 1; next state RELEASE.
REQ-014 RELEASE (1 cycle): ce_n_o=we_n_o=1. If byte B is pending, go to NEXT; otherwise go to IDLE.
REQ-015 NEXT: load byte B into d_o, then go to SETUP; cmd_ready_o stays 0 until the tone pair completes.
REQ-016 cmd_ready_o SHALL be 1 only in IDLE; a command offered outside IDLE is not accepted and SHALL be held by the source.
REQ-017 Back-to-back commands: minimum per-byte cost is 1 + MIN_STROBE + 1 cycles, plus 1 cycle in IDLE between commands.
REQ-018 d_o SHALL change only in IDLE, NEXT or RELEASE, never while ce_n_o=0.
REQ-019 If ready_i=0 throughout STROBE, the block SHALL hold STROBE indefinitely (unless the timeout feature is compiled in).

Reset
REQ-020 While res_n_i=0: state=IDLE, ce_n_o=1, we_n_o=1, d_o=8'h00, cmd_ready_o=0, busy_o=0, err_o=0, strobe counter=0, pending byte cleared.
REQ-021 cmd_ready_o SHALL rise on the first clock edge after res_n_i is released.
REQ-022 Reset asserted mid-STROBE SHALL deassert ce_n_o/we_n_o immediately (asynchronously); the partial command is discarded.

Configuration
REQ-023 Macro PSG_WR_TIMEOUT_EN, when defined: a STROBE lasting TIMEOUT_CYCLES cycles without exiting SHALL force RELEASE, set err_o=1, discard any pending byte B, and return to IDLE.
REQ-024 err_o SHALL be cleared only by reset.
REQ-025 Without PSG_WR_TIMEOUT_EN: no timeout counter, err_o tied to 0, and the wait in REQ-019 is unbounded.

Verification
REQ-026 Tone ch0, data 10'h0FE, ready_i=1 -> two strobes with d_o=8'h8E then 8'h0F; each strobe lasts 2 cycles; cmd_ready_o returns high 9 cycles after acceptance.
REQ-027 Attenuation ch2, data 4'h5 -> single strobe with d_o=8'hD5; noise, data 3'h4 -> single strobe with d_o=8'hE4.
REQ-028 ready_i held 0 for 20 cycles after strobe start -> ce_n_o low for 20 cycles plus 1, d_o stable throughout, no second command accepted.
REQ-029 With PSG_WR_TIMEOUT_EN, ready_i stuck 0 on tone byte A -> release after 64 strobe cycles, err_o=1, byte B never driven, cmd_ready_o=1.
REQ-030 Reset pulsed during STROBE of byte A -> ce_n_o=1 within the same cycle, d_o=8'h00, and a new attenuation command after reset encodes correctly.

Source files
------------

// File: rtl/psg_bus_writer.sv
// Byte-strobe writer for an SN76489-style PSG: encodes tone/attenuation/noise/raw commands into PSG bytes.
// Optional macro PSG_WR_TIMEOUT_EN adds a strobe timeout that aborts the command and sets the sticky err_o.
module psg_bus_writer #(
  parameter int MIN_STROBE     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock_i,
  input  logic       res_n_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_type_i,
  input  logic [1:0] cmd_chan_i,
  input  logic [9:0] cmd_data_i,
  output logic       ce_n_o,
  output logic       we_n_o,
  output logic [7:0] d_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_NEXT    = 3'd4
  } state_t;

  localparam logic [7:0] MIN_M1 = 8'(MIN_STROBE - 1);
  localparam logic [7:0] TO_M1  = 8'(TIMEOUT_CYCLES - 1);

  if (MIN_STROBE < 1 || MIN_STROBE > 15) begin : g_bad_min_strobe
    $error("MIN_STROBE must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  // First (or only) PSG byte of a command; tone carries its high bits in a second byte.
  function automatic logic [7:0] enc_first(input logic [1:0] typ, input logic [1:0] chan,
                                           input logic [9:0] data);
    logic [7:0] b;
    case (typ)
      2'b00:   b = {1'b1, chan, 1'b0, data[3:0]};
      2'b01:   b = {1'b1, chan, 1'b1, data[3:0]};
      2'b10:   b = {5'b11100, data[2:0]};
      2'b11:   b = data[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_pend;
  logic [5:0] r_hi;
  logic [7:0] r_d;
  logic       r_rdy;
  logic       r_ce_n;
  logic       r_busy;
  logic       w_accept;
  logic       w_strobe_done;
  logic       w_timeout;
  logic       w_rdy_nxt;
  logic       w_ce_n_nxt;
  logic       w_busy_nxt;

  assign w_accept      = cmd_valid_i && r_rdy;
  assign w_strobe_done = (r_cnt >= MIN_M1) && ready_i;

`ifdef PSG_WR_TIMEOUT_EN
  logic r_err;
  assign w_timeout = (r_state == ST_STROBE) && !w_strobe_done && (r_cnt == TO_M1);

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end
  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: w_state_nxt = ST_STROBE;
      ST_STROBE: begin
        if (w_strobe_done || w_timeout) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_state_nxt = ST_STROBE;
        end
      end
      ST_RELEASE: begin
        if (r_pend) begin
          w_state_nxt = ST_NEXT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_NEXT: w_state_nxt = ST_SETUP;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so that every PSG-side output comes straight from a flop.
  always_comb begin
    w_rdy_nxt  = 1'b0;
    w_ce_n_nxt = 1'b1;
    w_busy_nxt = 1'b1;
    case (w_state_nxt)
      ST_IDLE: begin
        w_rdy_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
      end
      ST_STROBE: w_ce_n_nxt = 1'b0;
      ST_SETUP, ST_RELEASE, ST_NEXT: begin
        w_rdy_nxt  = 1'b0;
        w_ce_n_nxt = 1'b1;
      end
      default: begin
        w_rdy_nxt  = 1'b0;
        w_ce_n_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Registered control outputs; async reset pulls ce_n/we_n high immediately.
  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_rdy  <= 1'b0;
      r_ce_n <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_rdy  <= w_rdy_nxt;
      r_ce_n <= w_ce_n_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // Strobe-length counter: zero outside STROBE, saturating inside.
  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_cnt <= 8'd0;
    end else if (r_state != ST_STROBE) begin
      r_cnt <= 8'd0;
    end else if (r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Data byte and pending tone high byte; d_o only moves on accept or when byte B is loaded.
  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_d    <= 8'h00;
      r_hi   <= 6'd0;
      r_pend <= 1'b0;
    end else if (r_state == ST_IDLE && w_accept) begin
      r_d    <= enc_first(cmd_type_i, cmd_chan_i, cmd_data_i);
      r_hi   <= cmd_data_i[9:4];
      r_pend <= (cmd_type_i == 2'b00);
    end else if (r_state == ST_NEXT) begin
      r_d    <= {2'b00, r_hi};
      r_pend <= 1'b0;
    end else if (w_timeout) begin
      r_pend <= 1'b0;
    end else begin
      r_d    <= r_d;
      r_pend <= r_pend;
    end
  end

  assign cmd_ready_o = r_rdy;
  assign ce_n_o      = r_ce_n;
  assign we_n_o      = r_ce_n;
  assign d_o         = r_d;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_psg_bus_writer.sv
// Directed self-checking bench for psg_bus_writer; timeout checks compile in with PSG_WR_TIMEOUT_EN.
module tb_psg_bus_writer;

  logic       clk = 1'b0;
  logic       res_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [1:0] cmd_chan;
  logic [9:0] cmd_data;
  logic       ce_n;
  logic       we_n;
  logic [7:0] d;
  logic       ready;
  logic       busy;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;

  psg_bus_writer #(.MIN_STROBE(2), .TIMEOUT_CYCLES(64)) dut (
    .clock_i     (clk),
    .res_n_i     (res_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_type_i  (cmd_type),
    .cmd_chan_i  (cmd_chan),
    .cmd_data_i  (cmd_data),
    .ce_n_o      (ce_n),
    .we_n_o      (we_n),
    .d_o         (d),
    .ready_i     (ready),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Offer a command and return 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [1:0] c, input logic [9:0] v);
    int k;
    @(negedge clk);
    cmd_type  = t;
    cmd_chan  = c;
    cmd_data  = v;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("accept_timeout", (k < 200) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Single-byte command with ready_i=1: SETUP, 2x STROBE, RELEASE, IDLE.
  task automatic run_single(input logic [7:0] exp_b);
    logic ce_e [5];
    ce_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check_val("single_ce_n", 32'(ce_n), 32'(ce_e[j]));
      check_val("single_we_n", 32'(we_n), 32'(ce_e[j]));
      check_val("single_d", 32'(d), 32'(exp_b));
      check_val("single_rdy", 32'(cmd_ready), (j == 4) ? 32'd1 : 32'd0);
      check_val("single_busy", 32'(busy), (j == 4) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    logic       ce_e [10];
    logic [7:0] d_e  [10];
    int         n;
    res_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = 2'b00;
    cmd_chan  = 2'b00;
    cmd_data  = 10'd0;
    ready     = 1'b1;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ce_n", 32'(ce_n), 32'd1);
    check_val("rst_we_n", 32'(we_n), 32'd1);
    check_val("rst_d", 32'(d), 32'h00);
    check_val("rst_rdy", 32'(cmd_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    res_n = 1'b1;
    @(negedge clk);
    check_val("rdy_after_rst", 32'(cmd_ready), 32'd1);

    // Tone ch0 0x0FE: two bytes, ready back 9 cycles after accept
    ce_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    d_e  = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    send(2'b00, 2'd0, 10'h0FE);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check_val("tone_ce_n", 32'(ce_n), 32'(ce_e[j]));
      check_val("tone_d", 32'(d), 32'(d_e[j]));
      check_val("tone_rdy", 32'(cmd_ready), (j == 9) ? 32'd1 : 32'd0);
    end

    send(2'b01, 2'd2, 10'h005);
    run_single(8'hD5);
    send(2'b10, 2'd3, 10'h3FC);
    run_single(8'hE4);
    send(2'b11, 2'd1, 10'h2A5);
    run_single(8'hA5);

    // Stalled PSG: ready_i low for 20 strobe cycles, a second command held meanwhile
    ready = 1'b0;
    send(2'b01, 2'd1, 10'h00A);
    cmd_type  = 2'b11;
    cmd_data  = 10'h055;
    cmd_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ce_n == 1'b0) begin
        n++;
        check_val("stall_d", 32'(d), 32'hBA);
        check_val("stall_rdy", 32'(cmd_ready), 32'd0);
        if (n == 21) begin
          ready     = 1'b1;
          cmd_valid = 1'b0;
        end
      end else if (n > 0) begin
        break;
      end
    end
    check_val("stall_len", 32'(n), 32'd21);
    check_val("stall_d_release", 32'(d), 32'hBA);
    @(negedge clk);
    check_val("stall_rdy_end", 32'(cmd_ready), 32'd1);
`ifndef PSG_WR_TIMEOUT_EN
    check_val("err_tied_low", 32'(err), 32'd0);
`endif

`ifdef PSG_WR_TIMEOUT_EN
    // Stuck PSG on tone byte A: abort after 64 strobe cycles, byte B never driven
    ready = 1'b0;
    send(2'b00, 2'd0, 10'h0FE);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ce_n == 1'b0) begin
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    check_val("to_len", 32'(n), 32'd64);
    check_val("to_err", 32'(err), 32'd1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_val("to_no_byte_b_ce", 32'(ce_n), 32'd1);
      check_val("to_no_byte_b_d", 32'(d), 32'h8E);
      check_val("to_rdy", 32'(cmd_ready), 32'd1);
      check_val("to_err_sticky", 32'(err), 32'd1);
    end
    ready = 1'b1;
`endif

    // Reset during byte A strobe
    send(2'b00, 2'd0, 10'h0FE);
    n = 0;
    while (ce_n == 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_mid_reach_strobe", 32'(ce_n), 32'd0);
    res_n = 1'b0;
    #1;
    check_val("rst_mid_ce_n", 32'(ce_n), 32'd1);
    check_val("rst_mid_we_n", 32'(we_n), 32'd1);
    check_val("rst_mid_d", 32'(d), 32'h00);
    check_val("rst_mid_rdy", 32'(cmd_ready), 32'd0);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    check_val("rst_mid_rdy_up", 32'(cmd_ready), 32'd1);
    check_val("rst_mid_idle_ce", 32'(ce_n), 32'd1);
    send(2'b01, 2'd1, 10'h003);
    run_single(8'hB3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
